bcd_countdown_timer: RTL and testbench

//  mm:ss countdown timer in BCD, driven by the slow square wave from the clock divider.

---
 rtl/bcd_countdown_timer.sv | 157 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: mm:ss BCD countdown timer advanced by the rising edges
// of a slow, clk-synchronous tick square wave. All outputs are registered.
module bcd_countdown_timer #(
   parameter int MAX_MIN     = 99,
   parameter int ALARM_TICKS = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       load,
   input  logic [6:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       alarm,
   output logic       done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} state_t;

   // Alarm tick counter only needs to hold 0..ALARM_TICKS-1.
   localparam int ACW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS);
   localparam logic [ACW-1:0] ALARM_LAST = ACW'((ALARM_TICKS > 0) ? ALARM_TICKS - 1 : 0);
   localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);

   state_t          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;       // {min_tens, min_ones, sec_tens, sec_ones}
   logic            tick_prev_q, tick_prev_d;
   logic            running_q, running_d;
   logic            alarm_q, alarm_d;
   logic            done_q, done_d;
   logic [ACW-1:0]  acnt_q, acnt_d;

   logic            tick_rise;
   logic [6:0]      min_clamped;
   logic [5:0]      sec_clamped;
   logic [15:0]     cnt_dec;

   // Binary (0..99) to two BCD digits {tens, ones}.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   // One-second BCD borrow-chain decrement; 00:00 stays at 00:00.
   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = c;
      if (c != 16'h0000) begin
         if (so != 4'd0) begin
            so = so - 4'd1;
         end else begin
            so = 4'd9;
            if (st != 4'd0) begin
               st = st - 4'd1;
            end else begin
               st = 4'd5;
               if (mo != 4'd0) begin
                  mo = mo - 4'd1;
               end else begin
                  mo = 4'd9;
                  mt = mt - 4'd1;
               end
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   assign tick_rise   = tick_in & ~tick_prev_q;
   assign min_clamped = (load_min > MAX_MIN_L) ? MAX_MIN_L : load_min;
   assign sec_clamped = (load_sec > 6'd59) ? 6'd59 : load_sec;
   assign cnt_dec     = bcd_dec(cnt_q);

   // Next-state logic: load > stop > start > tick; an accepted command swallows the tick.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tick_prev_d = tick_in;
      done_d      = 1'b0;
      acnt_d      = acnt_q;
      if (load) begin
         state_d = ST_IDLE;
         cnt_d   = {to_bcd(min_clamped), to_bcd({1'b0, sec_clamped})};
         acnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && cnt_q != 16'h0000) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (stop) begin
                  state_d = ST_PAUSED;
               end else if (tick_rise) begin
                  cnt_d = cnt_dec;
                  if (cnt_dec == 16'h0000) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     acnt_d  = '0;
                  end
               end
            end
            ST_PAUSED: begin
               if (stop) state_d = ST_PAUSED;
               else if (start) state_d = ST_RUN;
            end
            ST_DONE: begin
               if (stop) begin
                  state_d = ST_IDLE;
                  acnt_d  = '0;
               end else if (tick_rise && ALARM_TICKS > 0) begin
                  if (acnt_q == ALARM_LAST) begin
                     state_d = ST_IDLE;
                     acnt_d  = '0;
                  end else begin
                     acnt_d = acnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      running_d = (state_d == ST_RUN);
      alarm_d   = (state_d == ST_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tick_prev_q <= 1'b0;
         running_q   <= 1'b0;
         alarm_q     <= 1'b0;
         done_q      <= 1'b0;
         acnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_prev_q <= tick_prev_d;
         running_q   <= running_d;
         alarm_q     <= alarm_d;
         done_q      <= done_d;
         acnt_q      <= acnt_d;
      end
   end

   assign {min_tens, min_ones, sec_tens, sec_ones} = cnt_q;
   assign running = running_q;
   assign alarm   = alarm_q;
   assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: two instances sharing stimulus,
// one with a held alarm (ALARM_TICKS=0) and one that auto-clears (ALARM_TICKS=2).
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       reset, tick_in, load, start, stop;
   logic [6:0] load_min;
   logic [5:0] load_sec;

   logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
   logic       a_run, a_alm, a_done, b_run, b_alm, b_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_countdown_timer #(.MAX_MIN(99), .ALARM_TICKS(0)) dut_a (
      .clk(clk), .reset(reset), .tick_in(tick_in), .load(load),
      .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
      .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
      .running(a_run), .alarm(a_alm), .done(a_done));

   bcd_countdown_timer #(.MAX_MIN(99), .ALARM_TICKS(2)) dut_b (
      .clk(clk), .reset(reset), .tick_in(tick_in), .load(load),
      .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
      .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
      .running(b_run), .alarm(b_alm), .done(b_done));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check digits and {running, alarm, done} of the held-alarm instance.
   task automatic chk_a(input string tag, input logic [15:0] digits,
                        input logic r, input logic al, input logic d);
      chk({tag, ".digits"}, {a_mt, a_mo, a_st, a_so}, digits);
      chk({tag, ".flags"}, {13'd0, a_run, a_alm, a_done}, {13'd0, r, al, d});
   endtask

   task automatic chk_b(input string tag, input logic [15:0] digits,
                        input logic r, input logic al, input logic d);
      chk({tag, ".b_digits"}, {b_mt, b_mo, b_st, b_so}, digits);
      chk({tag, ".b_flags"}, {13'd0, b_run, b_alm, b_done}, {13'd0, r, al, d});
   endtask

   // Advance one clock; inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_load(input logic [6:0] m, input logic [5:0] s);
      load_min = m; load_sec = s; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic rise();
      tick_in = 1'b1; cyc();
   endtask

   task automatic fall();
      tick_in = 1'b0; cyc();
   endtask

   initial begin
      reset = 1'b0; tick_in = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
      load_min = 7'd0; load_sec = 6'd0;
      @(negedge clk);
      cyc(); cyc();
      chk_a("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      cyc();

      // 00:03 counted down to done
      do_load(7'd0, 6'd3);
      chk_a("t1_load", 16'h0003, 1'b0, 1'b0, 1'b0);
      do_start();
      chk_a("t1_start", 16'h0003, 1'b1, 1'b0, 1'b0);
      rise(); chk_a("t1_r1", 16'h0002, 1'b1, 1'b0, 1'b0); fall();
      chk_a("t1_hold", 16'h0002, 1'b1, 1'b0, 1'b0);
      rise(); chk_a("t1_r2", 16'h0001, 1'b1, 1'b0, 1'b0); fall();
      rise(); chk_a("t1_r3", 16'h0000, 1'b0, 1'b1, 1'b1);
      chk_b("t1_r3", 16'h0000, 1'b0, 1'b1, 1'b1);
      fall(); chk_a("t1_after", 16'h0000, 1'b0, 1'b1, 1'b0);

      // Alarm auto-clear after two rises (b) versus held alarm (a)
      rise(); chk_b("t6_r1", 16'h0000, 1'b0, 1'b1, 1'b0); fall();
      rise(); chk_b("t6_r2", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk_a("t6_held", 16'h0000, 1'b0, 1'b1, 1'b0); fall();
      start = 1'b1; cyc(); start = 1'b0;
      chk_a("t6_start_ign", 16'h0000, 1'b0, 1'b1, 1'b0);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk_a("t6_stop", 16'h0000, 1'b0, 1'b0, 1'b0);

      // Borrow across the minutes digits
      do_load(7'd1, 6'd0); do_start();
      rise(); chk_a("t2_0100", 16'h0059, 1'b1, 1'b0, 1'b0); fall();
      do_load(7'd10, 6'd0); do_start();
      rise(); chk_a("t2_1000", 16'h0959, 1'b1, 1'b0, 1'b0); fall();

      // Load clamp
      do_load(7'd127, 6'd63);
      chk_a("t3_clamp", 16'h9959, 1'b0, 1'b0, 1'b0);
      do_start();
      rise(); chk_a("t3_dec", 16'h9958, 1'b1, 1'b0, 1'b0); fall();

      // Pause, ignored ticks, start coincident with a rise
      do_load(7'd0, 6'd5); do_start();
      stop = 1'b1; cyc(); stop = 1'b0;
      chk_a("t4_pause", 16'h0005, 1'b0, 1'b0, 1'b0);
      rise(); fall(); rise(); fall();
      chk_a("t4_ign", 16'h0005, 1'b0, 1'b0, 1'b0);
      start = 1'b1; tick_in = 1'b1; cyc(); start = 1'b0;
      chk_a("t4_resume", 16'h0005, 1'b1, 1'b0, 1'b0);
      fall();
      rise(); chk_a("t4_dec", 16'h0004, 1'b1, 1'b0, 1'b0); fall();

      // load + stop + rise together while running
      do_load(7'd0, 6'd10); do_start();
      load_min = 7'd2; load_sec = 6'd0;
      load = 1'b1; stop = 1'b1; tick_in = 1'b1;
      cyc();
      load = 1'b0; stop = 1'b0;
      chk_a("t5_prio", 16'h0200, 1'b0, 1'b0, 1'b0);
      fall();

      // start at 00:00 stays idle
      do_load(7'd0, 6'd0); do_start();
      chk_a("idle_zero", 16'h0000, 1'b0, 1'b0, 1'b0);

      // reset mid-run
      do_load(7'd5, 6'd30); do_start();
      chk_a("pre_rst", 16'h0530, 1'b1, 1'b0, 1'b0);
      reset = 1'b0; cyc();
      chk_a("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk_b("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b1; cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
